jtframe_rom_slot: RTL and testbench
===================================

Name: jtframe_rom_slot

Overview:
- CPU-side ROM responder for the romwait/gated-CPU path.
- Accepts a byte-addressed ROM request (`cs` + `addr`), serves it from a 2-line cache of 32-bit words, and on a miss fetches the word over the SDRAM request/ack/data_ok handshake.
- Reports data validity on `ok`, which is the `rom_ok` that the CPU wait logic consumes.
- Sits between a core's Z80 wrapper and the SDRAM arbiter slot.

Parameters:
- AW, 16: CPU byte address width.
- DW, 8: CPU data width. Only 8 and 16 are legal; with 16, `addr[0]` is ignored.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high; single clock domain.
- cs  in  1  CPU ROM chip select; request is valid while high.
- addr  in  AW  CPU byte address.
- dout  out  DW  read data, valid while `ok`=1.
- ok  out  1  data valid for the current `addr` (`rom_ok`).
- sdram_addr  out  AW-2  32-bit word address of the pending fetch.
- sdram_req  out  1  fetch request; held high until `sdram_ack`.
- sdram_ack  in  1  one-cycle pulse: arbiter accepted the request.
- data_ok  in  1  one-cycle pulse: `sdram_din` valid.
- sdram_din  in  32  fetched word, little-endian byte lanes.

Behaviour:
- Reset (async) values:
  - Both line valid bits cleared; `ok`=0; `dout`=0; `sdram_req`=0; `sdram_addr`=0.
  - Replacement pointer = line 0; FSM in IDLE.
- Cache: two lines, each holding tag = `addr[AW-1:2]`, a 32-bit word and a valid bit.
  - Hit = `cs` & (valid & tag match) on either line.
- Byte lane select:
  - DW=8: `addr[1:0]`.
  - DW=16: `addr[1]`.
- Hit path, 1-cycle latency:
  - The cycle `cs` & hit is sampled, `dout` is registered from the line and `addr` is latched.
  - `ok` rises the next cycle.
  - `ok` = `ok_r` & `cs` & (`addr` == latched addr) — combinational drop in the same cycle `addr` changes or `cs` falls.
- FSM:
  - IDLE: if `cs` & !hit → REQ; `sdram_addr` ← `addr[AW-1:2]`; `sdram_req` ← 1.
  - REQ: hold `sdram_req`/`sdram_addr` stable; on `sdram_ack` → WAIT, `sdram_req` ← 0.
  - WAIT: on `data_ok` → write `sdram_din` into the line chosen by the pointer; set valid; toggle pointer; → IDLE.
  - The next cycle re-evaluates as a hit, so miss latency = ack delay + data delay + 2 cycles.
- `sdram_ack` and `data_ok` in the same cycle while in REQ: treat as both; complete the fill, go directly to IDLE.
- `data_ok` while in IDLE or REQ (without ack): ignored.
- `addr` changes or `cs` drops mid-fetch: the fetch is not aborted; the line is filled with the original tag. `ok` stays 0 until the current `addr` hits.
- Fetching a tag already resident (cannot happen via FSM) is not required to be handled.
- `rst` mid-fetch: FSM to IDLE, `sdram_req`=0 immediately. Any later `data_ok` from the arbiter is ignored.
- Only one outstanding fetch at a time.

Optional Feature:
JTFRAME_ROMSLOT_STATS_EN
- Defined:
  - Adds output ports `hit_cnt` [15:0] and `miss_cnt` [15:0], both reset to 0.
  - `hit_cnt` increments on each hit-path latch where the latched addr changed (one count per new access).
  - `miss_cnt` increments on each IDLE→REQ transition.
  - Both counters saturate at 16'hFFFF.
- Undefined: ports absent; no counter logic.

Decomposition:
- Shared package `jtframe_rom_pkg`:
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2).
  - Constant `ROM_WORD_W` = 32.
  - Byte-lane extraction function.
- Sub-module `jtframe_rom_slot_line`: one cache line (tag/data/valid registers, match compare, write port). Instantiated twice.

Test Plan:
- Cold miss: reset, `cs`=1, `addr`=16'h0005; arbiter acks after 3 cycles and returns `data_ok` with 32'hDDCCBBAA 4 cycles later → `sdram_addr`=14'h0001, one `miss_cnt`; `ok`=1 with `dout`=8'hBB two cycles after `data_ok`.
- Hit same word: after the fill, step `addr` to 16'h0006 → `ok` drops the same cycle, `dout`=8'hCC with `ok`=1 one cycle later; `sdram_req` stays 0.
- Replacement: fill word 0x0001, then 0x0100, then 0x0200 → third fill evicts 0x0001; returning to `addr` 16'h0004 re-issues `sdram_req` with `sdram_addr`=14'h0001.
- Address change mid-fetch: miss at 16'h0010; change to 16'h0020 before `data_ok` → tag 0x0004 filled, then a second request for 0x0008; `ok` stays 0 until that fill completes.
- Simultaneous ack+`data_ok` in REQ → single fill, FSM back to IDLE, no stuck `sdram_req`.
- Reset mid-fetch: assert `rst` in WAIT → `sdram_req`/`ok`=0 immediately; a subsequent `data_ok` changes nothing; the next access misses.

Source files
------------

// File: rtl/jtframe_rom_pkg.sv
// Shared definitions for the jtframe ROM slot: FSM encoding, word width and
// the byte-lane extraction helper.
package jtframe_rom_pkg;

  localparam int unsigned ROM_WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } rom_state_e;

  // Pick one little-endian byte lane out of a 32-bit ROM word.
  function automatic logic [7:0] rom_lane(input logic [ROM_WORD_W-1:0] word,
                                          input logic [1:0]            sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/jtframe_rom_slot_line.sv
// One line of the ROM slot cache: tag, 32-bit word and valid bit, with a
// tag compare and a single write port used by the SDRAM fill path.
module jtframe_rom_slot_line
  import jtframe_rom_pkg::*;
#(
  parameter int unsigned TW = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TW-1:0]         lookup_tag_i,
  input  logic                  wr_en_i,
  input  logic [TW-1:0]         wr_tag_i,
  input  logic [ROM_WORD_W-1:0] wr_data_i,
  output logic                  hit_o,
  output logic [ROM_WORD_W-1:0] data_o
);

  logic [TW-1:0]         tag_q;
  logic [ROM_WORD_W-1:0] data_q;
  logic                  valid_q;

  // Line storage: loaded on a fill, invalidated by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (wr_en_i) begin
      tag_q   <= wr_tag_i;
      data_q  <= wr_data_i;
      valid_q <= 1'b1;
    end
  end

  assign hit_o  = valid_q && (tag_q == lookup_tag_i);
  assign data_o = data_q;

endmodule

// File: rtl/jtframe_rom_slot.sv
// CPU-side ROM responder: 2-line word cache in front of an SDRAM slot.
// Optional macro JTFRAME_ROMSLOT_STATS_EN adds hit_cnt/miss_cnt ports.
module jtframe_rom_slot
  import jtframe_rom_pkg::*;
#(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic [AW-1:0]         addr,
  output logic [DW-1:0]         dout,
  output logic                  ok,
  output logic [AW-3:0]         sdram_addr,
  output logic                  sdram_req,
  input  logic                  sdram_ack,
  input  logic                  data_ok,
  input  logic [ROM_WORD_W-1:0] sdram_din
`ifdef JTFRAME_ROMSLOT_STATS_EN
  ,
  output logic [15:0]           hit_cnt,
  output logic [15:0]           miss_cnt
`endif
);

  rom_state_e            state_q, state_d;
  logic                  req_q, req_d;
  logic [AW-3:0]         saddr_q, saddr_d;
  logic                  ptr_q;
  logic                  fill;

  logic                  hit0, hit1, hit;
  logic [ROM_WORD_W-1:0] data0, data1, word_sel;
  logic [DW-1:0]         lane_w;
  logic [AW-1:0]         addr_m;

  logic [DW-1:0]         dout_q;
  logic [AW-1:0]         addr_q;
  logic                  ok_r_q;

  jtframe_rom_slot_line #(.TW(AW-2)) u_line0 (
    .clk          (clk),
    .rst          (rst),
    .lookup_tag_i (addr[AW-1:2]),
    .wr_en_i      (fill && !ptr_q),
    .wr_tag_i     (saddr_q),
    .wr_data_i    (sdram_din),
    .hit_o        (hit0),
    .data_o       (data0)
  );

  jtframe_rom_slot_line #(.TW(AW-2)) u_line1 (
    .clk          (clk),
    .rst          (rst),
    .lookup_tag_i (addr[AW-1:2]),
    .wr_en_i      (fill && ptr_q),
    .wr_tag_i     (saddr_q),
    .wr_data_i    (sdram_din),
    .hit_o        (hit1),
    .data_o       (data1)
  );

  assign hit      = cs && (hit0 || hit1);
  assign word_sel = hit0 ? data0 : data1;

  generate
    if (DW == 16) begin : g_w16
      // Halfword mode: addr[0] is a don't-care for both lane and compare.
      always_comb begin
        lane_w = {rom_lane(word_sel, {addr[1], 1'b1}),
                  rom_lane(word_sel, {addr[1], 1'b0})};
        addr_m = {addr[AW-1:1], 1'b0};
      end
    end else begin : g_w8
      // Byte mode: full address selects the lane.
      always_comb begin
        lane_w = rom_lane(word_sel, addr[1:0]);
        addr_m = addr;
      end
    end
  endgenerate

  // Hit path: register the selected lane and the address it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      addr_q <= '0;
      ok_r_q <= 1'b0;
    end else if (hit) begin
      dout_q <= lane_w;
      addr_q <= addr_m;
      ok_r_q <= 1'b1;
    end else begin
      ok_r_q <= 1'b0;
    end
  end

  // ok drops combinationally as soon as the CPU moves away from the latched access.
  assign ok   = ok_r_q && cs && (addr_m == addr_q);
  assign dout = dout_q;

  // Fetch FSM state, request handshake and replacement pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      saddr_q <= '0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      saddr_q <= saddr_d;
      if (fill) ptr_q <= ~ptr_q;
    end
  end

  // Fetch FSM next state; ack and data_ok together in REQ complete the fill at once.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    saddr_d = saddr_q;
    fill    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs && !hit) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          saddr_d = addr[AW-1:2];
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          req_d = 1'b0;
          if (data_ok) begin
            fill    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (data_ok) begin
          fill    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign sdram_req  = req_q;
  assign sdram_addr = saddr_q;

`ifdef JTFRAME_ROMSLOT_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  // Saturating access statistics: one hit per new latched access, one miss per fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit && (!ok_r_q || addr_m != addr_q) && hit_cnt_q != '1)
        hit_cnt_q <= hit_cnt_q + 16'd1;
      if (state_q == ST_IDLE && state_d == ST_REQ && miss_cnt_q != '1)
        miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_jtframe_rom_slot.sv
// Directed bench for jtframe_rom_slot (default build, AW=16, DW=8).
module tb_jtframe_rom_slot;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        ok;
  logic [13:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack;
  logic        data_ok;
  logic [31:0] sdram_din;

  int vectors = 0;
  int errors  = 0;

  jtframe_rom_slot #(.AW(16), .DW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cs         (cs),
    .addr       (addr),
    .dout       (dout),
    .ok         (ok),
    .sdram_addr (sdram_addr),
    .sdram_req  (sdram_req),
    .sdram_ack  (sdram_ack),
    .data_ok    (data_ok),
    .sdram_din  (sdram_din)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; cs = 1'b0; addr = '0;
    sdram_ack = 1'b0; data_ok = 1'b0; sdram_din = '0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  // Arbiter model: wait (bounded) for a request, ack, then return the word.
  task automatic serve(input int ack_wait, input int data_wait,
                       input logic [31:0] word, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (sdram_req) seen = 1'b1;
      else step();
    end
    if (seen) begin
      repeat (ack_wait) step();
      sdram_ack = 1'b1; step(); sdram_ack = 1'b0;
      repeat (data_wait) step();
      sdram_din = word; data_ok = 1'b1; step(); data_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cs = 1'b0; addr = '0;
    sdram_ack = 1'b0; data_ok = 1'b0; sdram_din = '0;
    #1;
    vectors++; if (ok !== 1'b0) begin errors++; $display("FAIL reset_ok: got %b want 0", ok); end
    vectors++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end
    vectors++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", sdram_req); end
    vectors++; if (sdram_addr !== 14'h0) begin errors++; $display("FAIL reset_saddr: got %h want 0000", sdram_addr); end
    step(); rst = 1'b0; step();
    // data_ok while idle must not fill anything
    sdram_din = 32'hFFFFFFFF; data_ok = 1'b1; step(); data_ok = 1'b0;
    cs = 1'b1; addr = 16'h0000; step();
    vectors++; if (sdram_req !== 1'b1) begin errors++; $display("FAIL idle_dok_ignored_req: got %b want 1", sdram_req); end
    vectors++; if (ok !== 1'b0) begin errors++; $display("FAIL idle_dok_ignored_ok: got %b want 0", ok); end
  endtask

  task automatic test_cold_miss();
    apply_reset();
    cs = 1'b1; addr = 16'h0005; step();
    vectors++; if (sdram_req !== 1'b1) begin errors++; $display("FAIL cold_req: got %b want 1", sdram_req); end
    vectors++; if (sdram_addr !== 14'h0001) begin errors++; $display("FAIL cold_saddr: got %h want 0001", sdram_addr); end
    vectors++; if (ok !== 1'b0) begin errors++; $display("FAIL cold_ok_early: got %b want 0", ok); end
    step(); step();
    vectors++; if (sdram_req !== 1'b1 || sdram_addr !== 14'h0001) begin errors++; $display("FAIL cold_req_held: req %b addr %h want 1/0001", sdram_req, sdram_addr); end
    sdram_ack = 1'b1; step(); sdram_ack = 1'b0;
    vectors++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL cold_req_drop: got %b want 0", sdram_req); end
    step(); step(); step();
    sdram_din = 32'hDDCCBBAA; data_ok = 1'b1; step(); data_ok = 1'b0;
    vectors++; if (ok !== 1'b0) begin errors++; $display("FAIL cold_ok_fill_cycle: got %b want 0", ok); end
    step();
    vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL cold_ok: got %b want 1", ok); end
    vectors++; if (dout !== 8'hBB) begin errors++; $display("FAIL cold_dout: got %h want BB", dout); end
    vectors++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL cold_no_rereq: got %b want 0", sdram_req); end
  endtask

  task automatic test_hit_same_word();
    addr = 16'h0006; #1;
    vectors++; if (ok !== 1'b0) begin errors++; $display("FAIL hit_ok_drop: got %b want 0", ok); end
    step();
    vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL hit_ok: got %b want 1", ok); end
    vectors++; if (dout !== 8'hCC) begin errors++; $display("FAIL hit_dout: got %h want CC", dout); end
    vectors++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL hit_req: got %b want 0", sdram_req); end
    cs = 1'b0; #1;
    vectors++; if (ok !== 1'b0) begin errors++; $display("FAIL hit_cs_drop: got %b want 0", ok); end
    cs = 1'b1; addr = 16'h0007; step();
    vectors++; if (ok !== 1'b1 || dout !== 8'hDD) begin errors++; $display("FAIL hit_byte3: ok %b dout %h want 1/DD", ok, dout); end
  endtask

  task automatic test_replacement();
    bit seen;
    logic [15:0] a [3] = '{16'h0004, 16'h0401, 16'h0802};
    logic [31:0] w [3] = '{32'hA3A2A1A0, 32'hB3B2B1B0, 32'hC3C2C1C0};
    logic [7:0]  e [3] = '{8'hA0, 8'hB1, 8'hC2};
    apply_reset();
    cs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr = a[i]; step();
      serve(0, 1, w[i], seen);
      vectors++; if (!seen) begin errors++; $display("FAIL repl_req_%0d: got no request want request", i); end
      step();
      vectors++; if (ok !== 1'b1 || dout !== e[i]) begin errors++; $display("FAIL repl_fill_%0d: ok %b dout %h want 1/%h", i, ok, dout, e[i]); end
    end
    addr = 16'h0401; step();
    vectors++; if (sdram_req !== 1'b0 || ok !== 1'b1 || dout !== 8'hB1) begin errors++; $display("FAIL repl_line1_kept: req %b ok %b dout %h want 0/1/B1", sdram_req, ok, dout); end
    addr = 16'h0004; step();
    vectors++; if (sdram_req !== 1'b1 || sdram_addr !== 14'h0001) begin errors++; $display("FAIL repl_evicted: req %b addr %h want 1/0001", sdram_req, sdram_addr); end
    vectors++; if (ok !== 1'b0) begin errors++; $display("FAIL repl_evicted_ok: got %b want 0", ok); end
  endtask

  task automatic test_addr_change_mid_fetch();
    bit seen;
    apply_reset();
    cs = 1'b1; addr = 16'h0010; step();
    vectors++; if (sdram_req !== 1'b1 || sdram_addr !== 14'h0004) begin errors++; $display("FAIL mid_req1: req %b addr %h want 1/0004", sdram_req, sdram_addr); end
    addr = 16'h0020;
    serve(1, 1, 32'h44332211, seen);
    vectors++; if (!seen || ok !== 1'b0 || sdram_req !== 1'b0) begin errors++; $display("FAIL mid_fill1: seen %b ok %b req %b want 1/0/0", seen, ok, sdram_req); end
    step();
    vectors++; if (sdram_req !== 1'b1 || sdram_addr !== 14'h0008 || ok !== 1'b0) begin errors++; $display("FAIL mid_req2: req %b addr %h ok %b want 1/0008/0", sdram_req, sdram_addr, ok); end
    serve(0, 0, 32'h88776655, seen);
    vectors++; if (!seen || ok !== 1'b0) begin errors++; $display("FAIL mid_fill2: seen %b ok %b want 1/0", seen, ok); end
    step();
    vectors++; if (ok !== 1'b1 || dout !== 8'h55) begin errors++; $display("FAIL mid_hit2: ok %b dout %h want 1/55", ok, dout); end
    addr = 16'h0011; step();
    vectors++; if (ok !== 1'b1 || dout !== 8'h22 || sdram_req !== 1'b0) begin errors++; $display("FAIL mid_orig_tag: ok %b dout %h req %b want 1/22/0", ok, dout, sdram_req); end
  endtask

  task automatic test_ack_and_data_together();
    apply_reset();
    cs = 1'b1; addr = 16'h0031; step();
    vectors++; if (sdram_req !== 1'b1 || sdram_addr !== 14'h000C) begin errors++; $display("FAIL both_req: req %b addr %h want 1/000C", sdram_req, sdram_addr); end
    // data_ok without ack in REQ is ignored
    sdram_din = 32'h99999999; data_ok = 1'b1; step(); data_ok = 1'b0;
    vectors++; if (sdram_req !== 1'b1) begin errors++; $display("FAIL both_dok_noack: req %b want 1", sdram_req); end
    sdram_din = 32'h0D0C0B0A; sdram_ack = 1'b1; data_ok = 1'b1; step();
    sdram_ack = 1'b0; data_ok = 1'b0;
    vectors++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL both_req_drop: req %b want 0", sdram_req); end
    step();
    vectors++; if (ok !== 1'b1 || dout !== 8'h0B) begin errors++; $display("FAIL both_hit: ok %b dout %h want 1/0B", ok, dout); end
    step();
    vectors++; if (sdram_req !== 1'b0 || ok !== 1'b1) begin errors++; $display("FAIL both_settled: req %b ok %b want 0/1", sdram_req, ok); end
  endtask

  task automatic test_reset_mid_fetch();
    bit seen;
    apply_reset();
    cs = 1'b1; addr = 16'h0050; step();
    serve(0, 0, 32'h53525150, seen);
    step();
    vectors++; if (!seen || ok !== 1'b1 || dout !== 8'h50) begin errors++; $display("FAIL rmf_prefill: seen %b ok %b dout %h want 1/1/50", seen, ok, dout); end
    addr = 16'h0060; step();
    vectors++; if (sdram_req !== 1'b1 || sdram_addr !== 14'h0018) begin errors++; $display("FAIL rmf_req: req %b addr %h want 1/0018", sdram_req, sdram_addr); end
    sdram_ack = 1'b1; step(); sdram_ack = 1'b0;
    addr = 16'h0050; step();
    vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL rmf_hit_in_wait: ok %b want 1", ok); end
    rst = 1'b1; #1;
    vectors++; if (ok !== 1'b0 || sdram_req !== 1'b0) begin errors++; $display("FAIL rmf_reset_now: ok %b req %b want 0/0", ok, sdram_req); end
    cs = 1'b0; step(); rst = 1'b0; step();
    sdram_din = 32'h63626160; data_ok = 1'b1; step(); data_ok = 1'b0;
    cs = 1'b1; addr = 16'h0060; step();
    vectors++; if (sdram_req !== 1'b1 || sdram_addr !== 14'h0018 || ok !== 1'b0) begin errors++; $display("FAIL rmf_late_dok: req %b addr %h ok %b want 1/0018/0", sdram_req, sdram_addr, ok); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_same_word();
    test_replacement();
    test_addr_change_mid_fetch();
    test_ack_and_data_together();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
